// File: rtl/map_ram_arbiter.sv
// map_ram_arbiter: shares the single read/write port (port B) of map_RAM between the
// sprite writer (0), the dot/pill scanner (1) and the maze reload sequencer (2).
// Round-robin grant with per-requester lock, read-data routing with a one-hot valid
// strobe aligned to RAM latency, and a watchdog that forcibly releases a long-held grant.
//
// Ports:
//   CLOCK_50, reset        clock and synchronous active-high reset
//   req_i, lock_i          per-requester request / hold-grant
//   addrN_i, wdataN_i      requester address and write data (N = 0..2)
//   wren_in_i              per-requester write enable
//   gnt_o                  registered one-hot (or zero) grant
//   ram_addr_o, ram_wdata_o, ram_wren_o, ram_q_i   RAM port B
//   rdata_o, rvalid_o      read data broadcast and per-requester valid strobe
//   timeout_o              sticky forced-release flag
module map_ram_arbiter #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 160,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [2:0]        req_i,
  input  logic [2:0]        lock_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [ADDR_W-1:0] addr2_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  input  logic [DATA_W-1:0] wdata2_i,
  input  logic [2:0]        wren_in_i,
  output logic [2:0]        gnt_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              ram_wren_o,
  input  logic [DATA_W-1:0] ram_q_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [2:0]        rvalid_o,
  output logic              timeout_o
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);

  typedef enum logic {StIdle, StOwned} state_e;

  state_e            state_q;
  logic [2:0]        gnt_q;
  logic [1:0]        last_q;
  logic [HoldW-1:0]  hold_q;
  logic              timeout_q;
  logic              rd_vld_q [RD_LAT];
  logic [1:0]        rd_id_q  [RD_LAT];

  logic [2:0]        gnt_d;
  logic              force_rel;
  logic [1:0]        owner_idx;
  logic              owner_req;
  logic              owner_lock;
  logic [2:0]        others;
  logic              rd_push;

  // Search order last+1, last+2, last (mod 3); the current owner is always 'last',
  // so it naturally ends up lowest priority.
  function automatic logic [2:0] rr_pick(input logic [2:0] cand, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= 3; k++) begin
      idx = 2'((int'(last) + k) % 3);
      if (res == 3'b000 && cand[idx]) res[idx] = 1'b1;
    end
    return res;
  endfunction

  function automatic logic [1:0] hot2idx(input logic [2:0] hot);
    case (hot)
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  always_comb begin
    owner_idx  = hot2idx(gnt_q);
    owner_req  = |(req_i & gnt_q);
    owner_lock = |(lock_i & gnt_q);
    others     = req_i & ~gnt_q;
    gnt_d      = gnt_q;
    force_rel  = 1'b0;
    if (state_q == StIdle) begin
      gnt_d = rr_pick(req_i, last_q);
    end else if (!owner_req) begin
      gnt_d = rr_pick(others, last_q);
    end else if (hold_q == HoldMax) begin
      // Watchdog: the dropped owner sits out this edge even if nobody else wants the port.
      gnt_d     = rr_pick(others, last_q);
      force_rel = 1'b1;
    end else if (!owner_lock) begin
      gnt_d = rr_pick(req_i, last_q);
    end
  end

  // Port B datapath, combinational from the registered grant.
  always_comb begin
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    case (gnt_q)
      3'b001: begin
        ram_addr_o  = addr0_i;
        ram_wdata_o = wdata0_i;
      end
      3'b010: begin
        ram_addr_o  = addr1_i;
        ram_wdata_o = wdata1_i;
      end
      3'b100: begin
        ram_addr_o  = addr2_i;
        ram_wdata_o = wdata2_i;
      end
      default: ;
    endcase
    ram_wren_o = (state_q == StOwned) && (|(wren_in_i & gnt_q));
    rd_push    = (state_q == StOwned) && !ram_wren_o;
    rdata_o    = ram_q_i;
    rvalid_o   = rd_vld_q[RD_LAT-1] ? (3'b001 << rd_id_q[RD_LAT-1]) : 3'b000;
    gnt_o      = gnt_q;
    timeout_o  = timeout_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= StIdle;
      gnt_q     <= 3'b000;
      last_q    <= 2'd2;
      hold_q    <= '0;
      timeout_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        rd_vld_q[i] <= 1'b0;
        rd_id_q[i]  <= 2'd0;
      end
    end else begin
      gnt_q   <= gnt_d;
      state_q <= (gnt_d == 3'b000) ? StIdle : StOwned;
      if (gnt_d == 3'b000) begin
        hold_q <= '0;
      end else begin
        last_q <= hot2idx(gnt_d);
        if (gnt_d != gnt_q) begin
          hold_q <= HoldW'(1);
        end else if (hold_q != HoldMax) begin
          hold_q <= hold_q + 1'b1;
        end
      end
      if (force_rel) timeout_q <= 1'b1;
      // In-flight reads keep shifting regardless of later grant changes.
      rd_vld_q[0] <= rd_push;
      rd_id_q[0]  <= owner_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_id_q[i]  <= rd_id_q[i-1];
      end
    end
  end

endmodule

// File: doc/map_ram_arbiter.md
# map_ram_arbiter

Arbitrates the single read/write port (port B) of `map_RAM` among three requesters: the sprite writer, the dot/pill scanner and the maze reload sequencer. It uses round-robin arbitration with a lock so that a multi-cycle read-modify-write sequence is never interleaved. It routes read data back with a per-requester valid strobe aligned to RAM latency, and a watchdog force-releases any owner that holds the port too long.

## Interface

- `ADDR_W`, 5: map RAM word address width (rows 0..29 used).
- `DATA_W`, 160: map RAM word width (40 cells × 4 bits).
- `RD_LAT`, 1: clock cycles from address presented to `ram_q` valid.
- `MAX_HOLD`, 64: maximum consecutive granted cycles for one owner before forced release.

- `CLOCK_50`, in, 1: clock; all logic rising-edge.
- `reset`, in, 1: synchronous, active-high.
- `req`, in, 3: per-requester request; bit0 writer, bit1 scanner, bit2 reloader.
- `lock`, in, 3: per-requester hold-grant-across-cycles.
- `addr0`/`addr1`/`addr2`, in, ADDR_W each: requester addresses.
- `wdata0`/`wdata1`/`wdata2`, in, DATA_W each: requester write data.
- `wren_in`, in, 3: per-requester write enable.
- `gnt`, out, 3: one-hot (or zero) registered grant.
- `ram_addr`, out, ADDR_W: to RAM port B address.
- `ram_wdata`, out, DATA_W: to RAM port B data.
- `ram_wren`, out, 1: to RAM port B write enable.
- `ram_q`, in, DATA_W: RAM port B read data.
- `rdata`, out, DATA_W: `ram_q` broadcast to all requesters.
- `rvalid`, out, 3: one-hot strobe marking `rdata` for a requester's read.
- `timeout`, out, 1: sticky; set on forced release, cleared only by reset.

## Operation

- States: IDLE (`gnt`=0) and OWNED (`gnt`=one-hot owner).
- Round-robin pointer `last` (2 bits) records the most recent owner. Search order is `last`+1, `last`+2, `last` (mod 3).
- IDLE: if any `req`, grant the first in search order on the next edge, go OWNED, and set `last`=winner. Otherwise stay IDLE.
- OWNED, evaluated every edge:
  - Owner `req`=0: re-arbitrate among other requests. Grant the next winner with no idle cycle, or go IDLE.
  - Owner `req`=1, `lock`=1, hold count < MAX_HOLD: keep grant.
  - Owner `req`=1, `lock`=0: re-arbitrate with the owner lowest priority. The owner keeps the grant only if no other `req`.
  - Hold count reaches MAX_HOLD: drop the owner regardless of `lock`, set `timeout`, and re-arbitrate excluding the dropped owner for that edge.
- Hold counter: reset to 1 on each new grant, increments while the same owner keeps the grant, saturates at MAX_HOLD.
- Datapath is combinational from the registered `gnt`:
  - `ram_addr`/`ram_wdata` come from the owner.
  - `ram_wren` = `wren_in[owner]` & OWNED.
  - In IDLE: `ram_addr`=0, `ram_wdata`=0, `ram_wren`=0.
- Read tracking: a shift pipeline RD_LAT deep carries (valid, id). An entry is pushed each cycle with OWNED & ~`ram_wren`. `rvalid[id]` is asserted when the entry exits. Entries already in flight complete even if the grant moves.
- `rdata` = `ram_q` always. It is meaningful only with `rvalid`.
- Requests from a requester whose `req` is low are ignored. `lock` without `req` has no effect.

## Timing

- Reset values:
  - `gnt`=0, state IDLE, `last`=2 (so the writer wins first)
  - hold count=0, read pipeline flushed, `rvalid`=0
  - `timeout`=0, `ram_wren`=0, `ram_addr`=0, `ram_wdata`=0
- Reset mid-transaction aborts the grant the same edge. No write is issued in the cycle after reset.
- Grant latency: `req` high at edge t (IDLE) → `gnt` high from t+1. The requester's access occurs in the first cycle `gnt` is seen high.
- Read latency: read issued in cycle c → `rvalid` and `rdata` valid in cycle c+RD_LAT.
- Handover: owner drops `req` at edge t → new `gnt` from t+1. At most one requester is granted per cycle, and `gnt` is never multi-hot.
- Forced release: `gnt` is low in the cycle after the MAX_HOLD-th granted cycle. The same owner can be regranted no earlier than one cycle after another requester has had a turn or the bus has idled.

## Test plan

- Single read: with `RD_LAT`=1, `req`=001, `addr0`=7 → `gnt`=001 next cycle, `ram_addr`=7, `ram_wren`=0. One cycle later `rvalid`=001 and `rdata` equals word 7.
- Locked RMW: writer `req`+`lock` for 4 cycles (read row 3, write row 3) while the scanner holds `req`. The scanner gets no grant until the writer drops `req`, then `gnt`=010 with no idle cycle. Row 3 holds the written value.
- Round-robin: all three request unlocked, each continuously. `gnt` sequence from reset is 001, 010, 100, 001 on consecutive cycles.
- Watchdog: `MAX_HOLD`=8, reloader holds `req`+`lock` with the scanner requesting. `gnt`=100 for exactly 8 cycles, then 010, and `timeout`=1 stays set.
- In-flight read across handover: scanner reads in its last granted cycle and the writer is granted next. `rvalid`=010 arrives while `gnt`=001, and there is no spurious `rvalid[0]`.
- Reset mid-write: assert `reset` during a writer write cycle. Next cycle `gnt`=0, `ram_wren`=0, `rvalid`=0, `timeout`=0.
